decode_sb: RTL and testbench

//  Parametrised decode stage for the 5-stage pipeline; successor to the fixed 16-bit decode stage.

---
 rtl/decode_sb.sv | 131 +++++++++++++
 tb/tb_decode_sb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sb.sv
// Decode stage: field split, immediate forming, 8-entry regfile read, load-use scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle writeback forwarding into the reads).
module decode_sb #(
   parameter int XLEN     = 16,
   parameter int PC_W     = 16,
   parameter int LOAD_LAT = 1,
   parameter int RET_REG  = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic [15:0]     instr_in,
   input  logic            bubble_in,
   input  logic [PC_W-1:0] pc_in,
   input  logic            we,
   input  logic [2:0]      target,
   input  logic [XLEN-1:0] write_data,
   output logic [XLEN-1:0] d_1,
   output logic [XLEN-1:0] d_2,
   output logic [PC_W-1:0] pc_out,
   output logic [2:0]      opcode_out,
   output logic [2:0]      s_1_out,
   output logic [2:0]      s_2_out,
   output logic [2:0]      tgt_out,
   output logic [3:0]      alu_op_out,
   output logic [XLEN-1:0] imm_out,
   output logic [5:0]      branch_code_out,
   output logic            bubble_out,
   output logic            stall,
   output logic            halt_out,
   output logic [XLEN-1:0] ret_val,
   output logic [15:0]     stall_count
);
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BR   = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;
   localparam logic [2:0] LAT     = 3'(LOAD_LAT);
   localparam logic [2:0] RET_IDX = 3'(RET_REG);

   logic [2:0]      op, ra, rb, rc, s_1, s_2;
   logic [XLEN-1:0] regs [8];
   logic [2:0]      busy [8];
   logic [XLEN-1:0] rd_1, rd_2, imm_next;
   logic [2:0]      tgt_next;
   logic            halt_next, issue_lw;

   assign op  = instr_in[15:13];
   assign ra  = instr_in[12:10];
   assign rb  = instr_in[9:7];
   assign rc  = instr_in[2:0];
   assign s_1 = rb;
   assign s_2 = (op == OP_SW) ? ra : rc;

   // r0 is never written, so it stays at its reset value of zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (we && target != 3'd0) begin
         regs[target] <= write_data;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign rd_1    = (we && target != 3'd0 && target == s_1) ? write_data : regs[s_1];
   assign rd_2    = (we && target != 3'd0 && target == s_2) ? write_data : regs[s_2];
   assign ret_val = (we && target != 3'd0 && target == RET_IDX) ? write_data : regs[RET_IDX];
`else
   assign rd_1    = regs[s_1];
   assign rd_2    = regs[s_2];
   assign ret_val = regs[RET_IDX];
`endif

   assign stall = ~bubble_in & (((busy[s_1] != 3'd0) && (s_1 != 3'd0)) ||
                                ((busy[s_2] != 3'd0) && (s_2 != 3'd0)));

   assign issue_lw = (op == OP_LW) && (ra != 3'd0) && !stall && !flush && !bubble_in;

   // a load leaving decode re-arms its entry ahead of the per-cycle countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) busy[i] <= 3'd0;
      end else begin
         for (int i = 1; i < 8; i++) begin
            if (issue_lw && ra == 3'(i))
               busy[i] <= LAT;
            else if (busy[i] != 3'd0)
               busy[i] <= busy[i] - 3'd1;
         end
      end
   end

   assign imm_next = (op == OP_LUI) ? {instr_in[9:0], {(XLEN-10){1'b0}}}
                                    : {{(XLEN-7){instr_in[6]}}, instr_in[6:0]};
   assign tgt_next = (flush || bubble_in || stall || op == OP_SW || op == OP_BR) ? 3'd0 : ra;
   assign halt_next = (op == OP_HALT) && (instr_in[6:0] != 7'd0) && !bubble_in && !flush && !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_1             <= '0;
         d_2             <= '0;
         pc_out          <= '0;
         opcode_out      <= 3'd0;
         s_1_out         <= 3'd0;
         s_2_out         <= 3'd0;
         tgt_out         <= 3'd0;
         alu_op_out      <= 4'd0;
         imm_out         <= '0;
         branch_code_out <= 6'd0;
         bubble_out      <= 1'b1;
         halt_out        <= 1'b0;
         stall_count     <= 16'd0;
      end else begin
         d_1             <= rd_1;
         d_2             <= rd_2;
         pc_out          <= pc_in;
         opcode_out      <= op;
         s_1_out         <= s_1;
         s_2_out         <= s_2;
         tgt_out         <= tgt_next;
         alu_op_out      <= instr_in[6:3];
         imm_out         <= imm_next;
         branch_code_out <= instr_in[12:7];
         bubble_out      <= flush | stall | bubble_in;
         halt_out        <= halt_next;
         if (stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_decode_sb.sv
// Scoreboard bench for decode_sb: one instance with LOAD_LAT=1, one with LOAD_LAT=3.
// Build with REGFILE_BYPASS_EN defined to check the forwarding variant.
module tb_decode_sb;
   localparam int N = 2;
   localparam logic [2:0] OP_ADD = 3'b000, OP_ADDI = 3'b001, OP_SW = 3'b100,
                          OP_LW = 3'b101, OP_BR = 3'b110, OP_HALT = 3'b111;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk, rst_n;
   logic        flush [N], bubble_in [N], we [N];
   logic [15:0] instr_in [N], pc_in [N], write_data [N];
   logic [2:0]  target [N];
   logic [15:0] d_1 [N], d_2 [N], pc_out [N], imm_out [N], ret_val [N], stall_count [N];
   logic [2:0]  opcode_out [N], s_1_out [N], s_2_out [N], tgt_out [N];
   logic [3:0]  alu_op_out [N];
   logic [5:0]  branch_code_out [N];
   logic        bubble_out [N], stall [N], halt_out [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_dut
         decode_sb #(.XLEN(16), .PC_W(16), .LOAD_LAT((gi == 0) ? 1 : 3), .RET_REG(3)) u_dut (
            .clk(clk), .rst_n(rst_n), .flush(flush[gi]), .instr_in(instr_in[gi]),
            .bubble_in(bubble_in[gi]), .pc_in(pc_in[gi]), .we(we[gi]), .target(target[gi]),
            .write_data(write_data[gi]), .d_1(d_1[gi]), .d_2(d_2[gi]), .pc_out(pc_out[gi]),
            .opcode_out(opcode_out[gi]), .s_1_out(s_1_out[gi]), .s_2_out(s_2_out[gi]),
            .tgt_out(tgt_out[gi]), .alu_op_out(alu_op_out[gi]), .imm_out(imm_out[gi]),
            .branch_code_out(branch_code_out[gi]), .bubble_out(bubble_out[gi]),
            .stall(stall[gi]), .halt_out(halt_out[gi]), .ret_val(ret_val[gi]),
            .stall_count(stall_count[gi]));
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          k;
      logic [15:0] d1, d2, pc, imm;
      logic [2:0]  op, s1, s2, tgt;
      logic [3:0]  alu;
      logic [5:0]  br;
      logic        bub, halt;
   } exp_t;

   exp_t        sb_q [$];
   logic [15:0] shadow [N][8];
   int          exp_sc [N];
   int          n_vec, n_err;
   logic [15:0] pc_ctr;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [15:0] f_ri(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [6:0] imm);
      return {op, ra, rb, imm};
   endfunction

   function automatic logic [15:0] f_rrr(input logic [2:0] op, input logic [2:0] ra,
                                         input logic [2:0] rb, input logic [2:0] rc);
      return {op, ra, rb, 4'b0000, rc};
   endfunction

   function automatic logic [15:0] rd(input int k, input logic [2:0] r, input logic w,
                                      input logic [2:0] wt, input logic [15:0] wd);
      if (r == 3'd0) return 16'h0000;
      if (BYP && w && wt != 3'd0 && wt == r) return wd;
      return shadow[k][r];
   endfunction

   // Drive one decode slot (called at posedge+1), predict, then compare one cycle later.
   task automatic step(input int k, input logic [15:0] ins, input logic bub, input logic fl,
                       input logic exp_stall, input logic w, input logic [2:0] wt,
                       input logic [15:0] wd);
      exp_t e, g;
      logic [2:0] op, ra, rb, rc;
      instr_in[k] = ins; bubble_in[k] = bub; flush[k] = fl; pc_in[k] = pc_ctr;
      we[k] = w; target[k] = wt; write_data[k] = wd;
      op = ins[15:13]; ra = ins[12:10]; rb = ins[9:7]; rc = ins[2:0];
      e.k   = k;
      e.op  = op;
      e.s1  = rb;
      e.s2  = (op == OP_SW) ? ra : rc;
      e.d1  = rd(k, e.s1, w, wt, wd);
      e.d2  = rd(k, e.s2, w, wt, wd);
      e.pc  = pc_ctr;
      e.imm = (op == 3'b011) ? {ins[9:0], 6'b0} : {{9{ins[6]}}, ins[6:0]};
      e.tgt = (fl || bub || exp_stall || op == OP_SW || op == OP_BR) ? 3'd0 : ra;
      e.alu = ins[6:3];
      e.br  = ins[12:7];
      e.bub = fl | bub | exp_stall;
      e.halt = (op == OP_HALT) && (ins[6:0] != 7'd0) && !bub && !fl && !exp_stall;
      sb_q.push_back(e);
      @(negedge clk);
      check("stall", 16'(stall[k]), 16'(exp_stall));
      @(posedge clk);
      #1;
      if (w && wt != 3'd0) shadow[k][wt] = wd;
      if (exp_stall) exp_sc[k]++;
      we[k] = 1'b0;
      if (sb_q.size() > 0) begin
         g = sb_q.pop_front();
         check("bubble_out", 16'(bubble_out[g.k]), 16'(g.bub));
         check("tgt_out", 16'(tgt_out[g.k]), 16'(g.tgt));
         check("halt_out", 16'(halt_out[g.k]), 16'(g.halt));
         check("opcode_out", 16'(opcode_out[g.k]), 16'(g.op));
         check("s_1_out", 16'(s_1_out[g.k]), 16'(g.s1));
         check("s_2_out", 16'(s_2_out[g.k]), 16'(g.s2));
         check("d_1", d_1[g.k], g.d1);
         check("d_2", d_2[g.k], g.d2);
         check("pc_out", pc_out[g.k], g.pc);
         check("imm_out", imm_out[g.k], g.imm);
         check("alu_op_out", 16'(alu_op_out[g.k]), 16'(g.alu));
         check("branch_code_out", 16'(branch_code_out[g.k]), 16'(g.br));
      end
      check("stall_count", stall_count[k], 16'(exp_sc[k]));
      check("ret_val", ret_val[k], shadow[k][3]);
      $display("dut%0d instr=%h bub=%b flush=%b we=%b stall=%b -> bubble_out=%b tgt=%0d imm=%h d_1=%h",
               k, ins, bub, fl, w, exp_stall, bubble_out[k], tgt_out[k], imm_out[k], d_1[k]);
      pc_ctr = pc_ctr + 16'd4;
   endtask

   task automatic idle_all();
      for (int k = 0; k < N; k++) begin
         instr_in[k] = 16'h0; bubble_in[k] = 1'b1; flush[k] = 1'b0; pc_in[k] = 16'h0;
         we[k] = 1'b0; target[k] = 3'd0; write_data[k] = 16'h0;
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < N; k++) begin
         exp_sc[k] = 0;
         for (int i = 0; i < 8; i++) shadow[k][i] = 16'h0;
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; pc_ctr = 16'h0100;
      clear_model();
      idle_all();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
         check("rst bubble_out", 16'(bubble_out[k]), 16'd1);
         check("rst tgt_out", 16'(tgt_out[k]), 16'd0);
         check("rst halt_out", 16'(halt_out[k]), 16'd0);
         check("rst stall", 16'(stall[k]), 16'd0);
         check("rst stall_count", stall_count[k], 16'd0);
         check("rst d_1", d_1[k], 16'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Writeback fill, including an ignored write to r0
      for (int k = 0; k < N; k++)
         for (int i = 0; i < 8; i++)
            step(k, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'(i),
                 (i == 0) ? 16'hDEAD : 16'(k * 16'h1000 + i * 16'h0111));

      // LOAD_LAT=1: single load-use bubble
      step(0, f_ri(OP_LW, 3'd2, 3'd1, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      step(0, f_rrr(OP_ADD, 3'd1, 3'd2, 3'd3), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
      step(0, f_rrr(OP_ADD, 3'd1, 3'd2, 3'd3), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

      // Immediates, halt and the r0 read
      step(0, 16'h6C01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      step(0, f_ri(OP_ADDI, 3'd1, 3'd2, 7'h7F), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      step(0, f_ri(OP_HALT, 3'd0, 3'd0, 7'h01), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      step(0, f_ri(OP_HALT, 3'd0, 3'd0, 7'h00), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      step(0, f_ri(OP_HALT, 3'd0, 3'd0, 7'h01), 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
      step(0, f_ri(OP_BR, 3'd3, 3'd4, 7'h55), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

      // Same-cycle writeback into a source register, then the settled value
      step(0, f_rrr(OP_ADD, 3'd1, 3'd5, 3'd2), 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'hBEEF);
      step(0, f_rrr(OP_ADD, 3'd1, 3'd5, 3'd2), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

      // LOAD_LAT=3: three stall cycles on sw using the load target
      step(1, f_ri(OP_LW, 3'd4, 3'd1, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      for (int c = 0; c < 3; c++)
         step(1, f_ri(OP_SW, 3'd4, 3'd1, 7'd2), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
      step(1, f_ri(OP_SW, 3'd4, 3'd1, 7'd2), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

      // Independent instructions cover the latency without stalling
      step(1, f_ri(OP_LW, 3'd4, 3'd1, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      for (int c = 0; c < 3; c++)
         step(1, f_ri(OP_ADDI, 3'd5, 3'd6, 7'd1), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      step(1, f_ri(OP_SW, 3'd4, 3'd1, 7'd2), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

      // flush together with stall still reports the stall and the countdown continues
      step(1, f_ri(OP_LW, 3'd4, 3'd1, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      step(1, f_ri(OP_SW, 3'd4, 3'd1, 7'd2), 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
      step(1, f_ri(OP_SW, 3'd4, 3'd1, 7'd2), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
      step(1, f_ri(OP_SW, 3'd4, 3'd1, 7'd2), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
      step(1, f_ri(OP_SW, 3'd4, 3'd1, 7'd2), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

      // Flushed load never arms the scoreboard
      step(1, f_ri(OP_LW, 3'd6, 3'd1, 7'd0), 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
      step(1, f_rrr(OP_ADD, 3'd1, 3'd6, 3'd6), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

      // Reset asserted in the middle of a stall
      step(1, f_ri(OP_LW, 3'd4, 3'd1, 7'd0), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      instr_in[1] = f_ri(OP_SW, 3'd4, 3'd1, 7'd2); bubble_in[1] = 1'b0; flush[1] = 1'b0;
      @(negedge clk);
      check("pre-reset stall", 16'(stall[1]), 16'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid-rst stall", 16'(stall[1]), 16'd0);
      check("mid-rst bubble_out", 16'(bubble_out[1]), 16'd1);
      check("mid-rst tgt_out", 16'(tgt_out[1]), 16'd0);
      check("mid-rst stall_count", stall_count[1], 16'd0);
      check("mid-rst ret_val", ret_val[1], 16'd0);
      check("mid-rst ret_val0", ret_val[0], 16'd0);
      idle_all();
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1, f_ri(OP_SW, 3'd4, 3'd1, 7'd2), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
      step(0, f_rrr(OP_ADD, 3'd1, 3'd2, 3'd3), 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
